lsu_stage_hs: RTL and testbench
===============================

// Module: lsu_stage_hs
// PURPOSE
//  Parametrised load/store + writeback stage that sits after execute. Takes one
//  decoded instruction per accept: ALU result, store data and DM/RF control.
//  Talks to data memory over a req/gnt/rvalid handshake with variable latency,
//  instead of a fixed one-cycle RAM. Handles byte-lane alignment and load
//  sign/zero extension, flags misaligned accesses, and emits one writeback record.
// PARAMETERS
//  DATA_W  32  datapath width; 32 or 64. Width code 2'b11 (double) is legal only at 64
//  ADDR_W  32  byte address and PC width
//  REG_AW  5   register-file address width
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous, active-high reset
//  stop         in   1         pipeline freeze (see BEHAVIOUR)
//  in_valid     in   1         instruction offered
//  in_ready     out  1         instruction accepted when in_valid&&in_ready
//  in_pc        in   ADDR_W    PC of instruction
//  in_aluout    in   DATA_W    ALU result; byte address for memory ops
//  in_wdata     in   DATA_W    store data (rs2)
//  in_dm_we     in   1         store
//  in_dm_re     in   1         load
//  in_dm_sign   in   1         1 = sign-extend load
//  in_dm_width  in   2         00 byte, 01 half, 10 word, 11 double
//  in_rfwe      in   1         register write enable
//  in_rfwsrc    in   2         00 none, 01 alu, 10 mem, 11 pc+4
//  in_rd        in   REG_AW    destination register
//  mem_req      out  1         bus request
//  mem_we       out  1         1 = write
//  mem_addr     out  ADDR_W    address, low log2(DATA_W/8) bits forced to 0
//  mem_be       out  DATA_W/8  byte enables (all 1s on reads)
//  mem_wdata    out  DATA_W    store data shifted onto its byte lanes
//  mem_gnt      in   1         request accepted this cycle
//  mem_rvalid   in   1         read data valid this cycle
//  mem_rdata    in   DATA_W    read data
//  wb_valid     out  1         writeback record valid
//  wb_rfwe      out  1         write register file
//  wb_rd        out  REG_AW    destination register
//  wb_data      out  DATA_W    writeback data
//  wb_exc       out  1         misaligned access; wb_rfwe forced to 0
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0 except in_ready=1 (when stop=0).
//  - FSM states: IDLE, REQ, RESP, WB. in_ready = (IDLE||WB) && !stop.
//  - On accept, all inputs are registered. Misaligned = addr % size != 0.
//  - Accept with non-memory op, or with a misaligned access: next state is WB.
//  - Accept with an aligned memory op: next state is REQ.
//  - REQ: mem_req=1 with registered addr/we/be/wdata, held stable until mem_gnt.
//    On gnt, a store goes to WB and a load goes to RESP.
//  - RESP: wait for mem_rvalid. On rvalid, capture mem_rdata and go to WB.
//  - WB: wb_valid = !stop, for exactly one cycle unless stop is asserted.
//    If stop=0, go to IDLE, or accept the next instruction (back-to-back) and
//    branch as from IDLE. If stop=1, hold WB.
//  - Latency from accept to wb_valid: 1 cycle for ALU/misaligned ops. A store
//    takes gnt_cycle+1; a load takes rvalid_cycle+1. mem_req can rise at the
//    earliest 1 cycle after accept.
//  - stop freezes only IDLE/WB. REQ and RESP keep advancing on gnt/rvalid so the
//    bus is never stalled.
//  - Byte enables: be = {1,3,F,FF}[width] << addr_lo. wdata = lane-replicated
//    data << 8*addr_lo. Load data = rdata >> 8*addr_lo, then sign/zero-extended
//    to DATA_W. Width 10 at DATA_W=64 sign-extends bit 31.
//  - wb_data source: rfwsrc 01 = aluout; 10 = extended load; 11 = pc+4
//    (modulo 2^ADDR_W, zero-extended); 00 = 0.
//  - wb_rfwe = rfwe && !exc && (rd != 0).
//  - Store+load both set: treated as a store. width=11 at DATA_W=32: wb_exc=1,
//    no bus access.
//  - mem_rvalid or mem_gnt outside REQ/RESP is ignored.
//  - Reset mid-operation: state goes to IDLE and mem_req drops on the next edge.
//    A late rvalid after reset is ignored.
// TESTING
//  1. ALU op: aluout=0x1234, rfwsrc=01, rd=5 -> 1 cycle later wb_valid, rd=5,
//     data=0x1234, no mem_req.
//  2. Store byte: addr 0x103, data 0xAB, gnt after 3 cycles -> mem_addr=0x100,
//     be=1000, wdata[31:24]=AB, wb_valid 1 cycle after gnt.
//  3. Load half signed: addr 0x102, rdata=0x8001_0000, rvalid 4 cycles after gnt
//     -> wb_data=0xFFFF8001.
//  4. Load word at 0x101 -> wb_exc=1, wb_rfwe=0, no mem_req, wb 1 cycle after
//     accept.
//  5. stop=1 in WB for 3 cycles -> wb_valid=0 and in_ready=0 throughout; one
//     wb_valid pulse after release. stop in RESP: rvalid still captured.
//  6. rst during RESP, then rvalid -> no wb_valid, state IDLE, mem_req=0.
//     DATA_W=64 double load at 0x8 is aligned.

Source files
------------

// File: rtl/lsu_stage_hs_if.sv
// ---------------------------------------------------------------------------
// lsu_stage_hs_if
//   Bundles the three handshakes of the load/store + writeback stage:
//     in_*  : instruction offer from execute (valid/ready)
//     mem_* : data-memory bus (req/gnt request phase, rvalid response phase)
//     wb_*  : single-cycle writeback record towards the register file
//   modport slave  : the stage itself (lsu_stage_hs)
//   modport master : the environment (execute stage, memory, register file)
// ---------------------------------------------------------------------------
interface lsu_stage_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
);
  // instruction offer
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_pc;
  logic [DATA_W-1:0]     in_aluout;
  logic [DATA_W-1:0]     in_wdata;
  logic                  in_dm_we;
  logic                  in_dm_re;
  logic                  in_dm_sign;
  logic [1:0]            in_dm_width;
  logic                  in_rfwe;
  logic [1:0]            in_rfwsrc;
  logic [REG_AW-1:0]     in_rd;

  // data-memory bus
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // writeback record
  logic                  wb_valid;
  logic                  wb_rfwe;
  logic [REG_AW-1:0]     wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_exc;

  modport slave (
    input  in_valid, in_pc, in_aluout, in_wdata, in_dm_we, in_dm_re,
           in_dm_sign, in_dm_width, in_rfwe, in_rfwsrc, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_rfwe, wb_rd, wb_data, wb_exc
  );

  modport master (
    output in_valid, in_pc, in_aluout, in_wdata, in_dm_we, in_dm_re,
           in_dm_sign, in_dm_width, in_rfwe, in_rfwsrc, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_rfwe, wb_rd, wb_data, wb_exc
  );
endinterface

// File: rtl/lsu_stage_hs.sv
// ---------------------------------------------------------------------------
// lsu_stage_hs
//   Load/store + writeback stage placed after execute. Accepts one decoded
//   instruction per in_valid&&in_ready, performs at most one data-memory
//   access over a req/gnt/rvalid bus of variable latency, aligns store data
//   onto byte lanes, extracts and sign/zero-extends load data, flags
//   misaligned accesses and emits a single writeback record.
//
// Ports
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   stop_i  : pipeline freeze; holds IDLE/WB only, bus phases keep running
//   busy_o  : stage is not IDLE
//   bus     : lsu_stage_hs_if.slave (in_* offer, mem_* bus, wb_* record)
//
// Parameters
//   DATA_W  : datapath width, 32 or 64 (width code 2'b11 legal only at 64)
//   ADDR_W  : byte address / PC width
//   REG_AW  : register-file address width
// ---------------------------------------------------------------------------
module lsu_stage_hs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stop_i,
  output logic               busy_o,
  lsu_stage_hs_if.slave      bus
);

  localparam int NB = DATA_W / 8;     // bytes per bus word
  localparam int LB = $clog2(NB);     // byte-offset bits within a bus word

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Registered instruction fields
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              re_q;
  logic              sign_q;
  logic [1:0]        width_q;
  logic              rfwe_q;
  logic [1:0]        rfwsrc_q;
  logic [REG_AW-1:0] rd_q;
  logic              exc_q;
  logic [DATA_W-1:0] rdata_q;

  // Access is misaligned when any offset bit below log2(size) is set, or
  // when the access is wider than the bus word (double on a 32-bit bus).
  function automatic logic misaligned(input logic [1:0] w, input logic [LB-1:0] lo);
    logic m;
    m = (int'(w) > LB);
    for (int i = 0; i < LB; i++) begin
      if ((i < int'(w)) && lo[i]) begin
        m = 1'b1;
      end
    end
    return m;
  endfunction

  // -------------------------------------------------------------------------
  // Accept path
  // -------------------------------------------------------------------------
  logic can_accept;
  logic accept;
  logic in_mem;
  logic in_exc;

  assign can_accept = ((state_q == S_IDLE) || (state_q == S_WB)) && !stop_i;
  assign accept     = can_accept && bus.in_valid;
  assign in_mem     = bus.in_dm_we || bus.in_dm_re;
  assign in_exc     = in_mem && misaligned(bus.in_dm_width, bus.in_aluout[LB-1:0]);

  assign bus.in_ready = can_accept;
  assign busy_o       = (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WB: begin
        if (!stop_i) begin
          if (bus.in_valid) begin
            // Misaligned and non-memory ops skip the bus entirely.
            state_d = (in_mem && !in_exc) ? S_REQ : S_WB;
          end else if (state_q == S_WB) begin
            state_d = S_IDLE;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d = we_q ? S_WB : S_RESP;
        end
      end
      S_RESP: begin
        if (bus.mem_rvalid) begin
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Instruction and read-data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      alu_q    <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      sign_q   <= 1'b0;
      width_q  <= 2'b00;
      rfwe_q   <= 1'b0;
      rfwsrc_q <= 2'b00;
      rd_q     <= '0;
      exc_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      pc_q     <= bus.in_pc;
      alu_q    <= bus.in_aluout;
      wdata_q  <= bus.in_wdata;
      we_q     <= bus.in_dm_we;
      // A store that also has load set is handled purely as a store.
      re_q     <= bus.in_dm_re && !bus.in_dm_we;
      sign_q   <= bus.in_dm_sign;
      width_q  <= bus.in_dm_width;
      rfwe_q   <= bus.in_rfwe;
      rfwsrc_q <= bus.in_rfwsrc;
      rd_q     <= bus.in_rd;
      exc_q    <= in_exc;
      // Cleared so an unaccessed load never returns a stale value.
      rdata_q  <= '0;
    end else if ((state_q == S_RESP) && bus.mem_rvalid) begin
      rdata_q  <= bus.mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Store lane steering
  // -------------------------------------------------------------------------
  logic [LB-1:0]     addr_lo;
  logic [LB+2:0]     lane_shamt;
  logic [NB-1:0]     be_base;
  logic [NB-1:0]     be_store;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] wdata_lane;
  logic [ADDR_W-1:0] addr_full;

  assign addr_lo    = alu_q[LB-1:0];
  assign lane_shamt = {addr_lo, 3'b000};
  assign addr_full  = ADDR_W'(alu_q);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      // Unshifted enable mask: 1, 3, F or FF depending on access size.
      assign be_base[gi] = (gi < (1 << width_q));
      // Replicate the low size-bytes of store data across the whole word.
      assign wdata_rep[gi*8 +: 8] =
          (width_q == 2'b00) ? wdata_q[7:0] :
          (width_q == 2'b01) ? wdata_q[(gi % 2)*8 +: 8] :
          (width_q == 2'b10) ? wdata_q[(gi % 4)*8 +: 8] :
                               wdata_q[(gi % 8)*8 +: 8];
    end
  endgenerate

  assign be_store   = be_base << addr_lo;
  assign wdata_lane = wdata_rep << lane_shamt;

  // Bus outputs are only driven while requesting; quiet otherwise.
  logic in_req;
  assign in_req = (state_q == S_REQ);

  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req && we_q;
  assign bus.mem_addr  = in_req ? {addr_full[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign bus.mem_be    = in_req ? (we_q ? be_store : {NB{1'b1}}) : '0;
  assign bus.mem_wdata = (in_req && we_q) ? wdata_lane : '0;

  // -------------------------------------------------------------------------
  // Load extraction and extension
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] load_shift;
  logic [DATA_W-1:0] load_ext;
  logic              sign_bit;
  logic              sign_fill;

  assign load_shift = rdata_q >> lane_shamt;

  always_comb begin
    sign_bit = 1'b0;
    case (width_q)
      2'b00:   sign_bit = load_shift[7];
      2'b01:   sign_bit = load_shift[15];
      2'b10:   sign_bit = load_shift[31];
      default: sign_bit = load_shift[DATA_W-1];
    endcase
  end

  assign sign_fill = sign_q && sign_bit;

  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      assign load_ext[gi] = (gi < (8 << width_q)) ? load_shift[gi] : sign_fill;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Writeback record
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_plus4;
  logic [DATA_W-1:0] wb_sel;
  logic              wb_fire;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    wb_sel = '0;
    case (rfwsrc_q)
      2'b01:   wb_sel = alu_q;
      2'b10:   wb_sel = load_ext;
      2'b11:   wb_sel = DATA_W'(pc_plus4);
      default: wb_sel = '0;
    endcase
  end

  // The record is presented only on the cycle it is actually delivered.
  assign wb_fire = (state_q == S_WB) && !stop_i;

  assign bus.wb_valid = wb_fire;
  assign bus.wb_rfwe  = wb_fire && rfwe_q && !exc_q && (rd_q != '0);
  assign bus.wb_rd    = wb_fire ? rd_q : '0;
  assign bus.wb_data  = wb_fire ? wb_sel : '0;
  assign bus.wb_exc   = wb_fire && exc_q;

endmodule

// File: tb/tb_lsu_stage_hs.sv
module tb_lsu_stage_hs;

  logic clk;
  logic rst;
  logic stop;
  logic stop64;
  logic busy32;
  logic busy64;

  int errors = 0;
  int checks = 0;

  lsu_stage_hs_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) if32 ();
  lsu_stage_hs_if #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) if64 ();

  lsu_stage_hs #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .stop_i(stop),
    .busy_o(busy32),
    .bus   (if32)
  );

  lsu_stage_hs #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) dut64 (
    .clk_i (clk),
    .rst_i (rst),
    .stop_i(stop64),
    .busy_o(busy64),
    .bus   (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic offer32(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic we, input logic re, input logic sgn, input logic [1:0] w,
                         input logic rfwe, input logic [1:0] src, input logic [4:0] rd);
    if32.in_valid    = 1'b1;
    if32.in_pc       = pc;
    if32.in_aluout   = alu;
    if32.in_wdata    = wd;
    if32.in_dm_we    = we;
    if32.in_dm_re    = re;
    if32.in_dm_sign  = sgn;
    if32.in_dm_width = w;
    if32.in_rfwe     = rfwe;
    if32.in_rfwsrc   = src;
    if32.in_rd       = rd;
  endtask

  task automatic offer64(input logic [63:0] alu, input logic [63:0] wd,
                         input logic we, input logic re, input logic sgn, input logic [1:0] w,
                         input logic [4:0] rd);
    if64.in_valid    = 1'b1;
    if64.in_pc       = 32'h0;
    if64.in_aluout   = alu;
    if64.in_wdata    = wd;
    if64.in_dm_we    = we;
    if64.in_dm_re    = re;
    if64.in_dm_sign  = sgn;
    if64.in_dm_width = w;
    if64.in_rfwe     = 1'b1;
    if64.in_rfwsrc   = 2'b10;
    if64.in_rd       = rd;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; stop64 = 1'b0;
    offer32(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0);
    if32.in_valid = 1'b0;
    if32.mem_gnt = 1'b0; if32.mem_rvalid = 1'b0; if32.mem_rdata = 32'h0;
    offer64(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    if64.in_valid = 1'b0;
    if64.mem_gnt = 1'b0; if64.mem_rvalid = 1'b0; if64.mem_rdata = 64'h0;

    // Reset state
    repeat (3) tick();
    sample();
    check("rst_busy",     64'(busy32), 64'd0);
    check("rst_in_ready", 64'(if32.in_ready), 64'd1);
    check("rst_mem_req",  64'(if32.mem_req), 64'd0);
    check("rst_mem_be",   64'(if32.mem_be), 64'd0);
    check("rst_wb_valid", 64'(if32.wb_valid), 64'd0);
    check("rst_wb_data",  64'(if32.wb_data), 64'd0);
    rst = 1'b0;
    tick();

    // ALU op: writeback one cycle after accept, no bus access
    offer32(32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 5'd5);
    sample();
    check("alu_in_ready", 64'(if32.in_ready), 64'd1);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("alu_wb_valid", 64'(if32.wb_valid), 64'd1);
    check("alu_wb_rd",    64'(if32.wb_rd), 64'd5);
    check("alu_wb_data",  64'(if32.wb_data), 64'h1234);
    check("alu_wb_rfwe",  64'(if32.wb_rfwe), 64'd1);
    check("alu_mem_req",  64'(if32.mem_req), 64'd0);
    tick();
    sample();
    check("alu_wb_done",  64'(if32.wb_valid), 64'd0);
    check("alu_idle",     64'(busy32), 64'd0);

    // Store byte at 0x103, grant on third request cycle
    offer32(32'h40, 32'h103, 32'hAB, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("sb_mem_req",   64'(if32.mem_req), 64'd1);
    check("sb_mem_we",    64'(if32.mem_we), 64'd1);
    check("sb_mem_addr",  64'(if32.mem_addr), 64'h100);
    check("sb_mem_be",    64'(if32.mem_be), 64'h8);
    check("sb_mem_wdata", 64'(if32.mem_wdata), 64'hAB000000);
    tick();
    sample();
    check("sb_hold_req",  64'(if32.mem_req), 64'd1);
    check("sb_hold_addr", 64'(if32.mem_addr), 64'h100);
    tick(); if32.mem_gnt = 1'b1;
    sample();
    check("sb_req_gnt",   64'(if32.mem_req), 64'd1);
    tick(); if32.mem_gnt = 1'b0;
    sample();
    check("sb_wb_valid",  64'(if32.wb_valid), 64'd1);
    check("sb_wb_rfwe",   64'(if32.wb_rfwe), 64'd0);
    check("sb_req_drop",  64'(if32.mem_req), 64'd0);
    tick();

    // Load half signed at 0x102, rvalid several cycles after grant
    offer32(32'h0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 5'd7);
    tick(); if32.in_valid = 1'b0; if32.mem_gnt = 1'b1;
    sample();
    check("lh_mem_we",    64'(if32.mem_we), 64'd0);
    check("lh_mem_be",    64'(if32.mem_be), 64'hF);
    check("lh_mem_addr",  64'(if32.mem_addr), 64'h100);
    tick(); if32.mem_gnt = 1'b0;
    sample();
    check("lh_resp_req",  64'(if32.mem_req), 64'd0);
    check("lh_resp_busy", 64'(busy32), 64'd1);
    repeat (3) tick();
    if32.mem_rvalid = 1'b1; if32.mem_rdata = 32'h80010000;
    sample();
    check("lh_no_wb_yet", 64'(if32.wb_valid), 64'd0);
    tick(); if32.mem_rvalid = 1'b0; if32.mem_rdata = 32'h0;
    sample();
    check("lh_wb_valid",  64'(if32.wb_valid), 64'd1);
    check("lh_wb_data",   64'(if32.wb_data), 64'hFFFF8001);
    check("lh_wb_rd",     64'(if32.wb_rd), 64'd7);
    tick();

    // Load byte unsigned at 0x101
    offer32(32'h0, 32'h101, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 5'd9);
    tick(); if32.in_valid = 1'b0; if32.mem_gnt = 1'b1;
    tick(); if32.mem_gnt = 1'b0; if32.mem_rvalid = 1'b1; if32.mem_rdata = 32'h00009A00;
    tick(); if32.mem_rvalid = 1'b0; if32.mem_rdata = 32'h0;
    sample();
    check("lbu_wb_data",  64'(if32.wb_data), 64'h9A);
    tick();

    // Store half at 0x102
    offer32(32'h0, 32'h102, 32'h55551234, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 5'd0);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("sh_mem_be",    64'(if32.mem_be), 64'hC);
    check("sh_mem_wdata", 64'(if32.mem_wdata), 64'h12340000);
    tick(); if32.mem_gnt = 1'b1;
    tick(); if32.mem_gnt = 1'b0;
    sample();
    check("sh_wb_valid",  64'(if32.wb_valid), 64'd1);
    tick();

    // Misaligned word load at 0x101
    offer32(32'h0, 32'h101, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 5'd4);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("mis_wb_valid", 64'(if32.wb_valid), 64'd1);
    check("mis_wb_exc",   64'(if32.wb_exc), 64'd1);
    check("mis_wb_rfwe",  64'(if32.wb_rfwe), 64'd0);
    check("mis_mem_req",  64'(if32.mem_req), 64'd0);
    tick();

    // Double load on a 32-bit bus is an exception
    offer32(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 5'd4);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("dbl32_exc",    64'(if32.wb_exc), 64'd1);
    check("dbl32_req",    64'(if32.mem_req), 64'd0);
    tick();

    // pc+4 wraps, then back-to-back ALU op to rd=0
    offer32(32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 5'd10);
    tick();
    offer32(32'h0, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 5'd0);
    sample();
    check("pc4_wb_data",  64'(if32.wb_data), 64'h0);
    check("pc4_wb_rd",    64'(if32.wb_rd), 64'd10);
    check("b2b_in_ready", 64'(if32.in_ready), 64'd1);
    tick(); if32.in_valid = 1'b0;
    sample();
    check("b2b_wb_valid", 64'(if32.wb_valid), 64'd1);
    check("b2b_wb_data",  64'(if32.wb_data), 64'h77);
    check("rd0_wb_rfwe",  64'(if32.wb_rfwe), 64'd0);
    tick();

    // stop held in WB for three cycles
    offer32(32'h0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 5'd2);
    tick(); if32.in_valid = 1'b0; stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("stop_wb_valid", 64'(if32.wb_valid), 64'd0);
      check("stop_in_ready", 64'(if32.in_ready), 64'd0);
      tick();
    end
    stop = 1'b0;
    sample();
    check("stop_rel_valid", 64'(if32.wb_valid), 64'd1);
    check("stop_rel_data",  64'(if32.wb_data), 64'h55);
    tick();
    sample();
    check("stop_one_pulse", 64'(if32.wb_valid), 64'd0);

    // stop during RESP: rvalid is still captured
    offer32(32'h0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 5'd6);
    tick(); if32.in_valid = 1'b0; if32.mem_gnt = 1'b1;
    tick(); if32.mem_gnt = 1'b0; stop = 1'b1; if32.mem_rvalid = 1'b1; if32.mem_rdata = 32'hCAFEF00D;
    tick(); if32.mem_rvalid = 1'b0; if32.mem_rdata = 32'h0;
    sample();
    check("sresp_held",   64'(if32.wb_valid), 64'd0);
    check("sresp_busy",   64'(busy32), 64'd1);
    stop = 1'b0;
    #1;
    check("sresp_valid",  64'(if32.wb_valid), 64'd1);
    check("sresp_data",   64'(if32.wb_data), 64'hCAFEF00D);
    tick();

    // gnt/rvalid while idle are ignored
    if32.mem_gnt = 1'b1; if32.mem_rvalid = 1'b1;
    tick(); tick();
    if32.mem_gnt = 1'b0; if32.mem_rvalid = 1'b0;
    sample();
    check("idle_ign_busy",  64'(busy32), 64'd0);
    check("idle_ign_valid", 64'(if32.wb_valid), 64'd0);

    // Reset during RESP, then a late rvalid
    offer32(32'h0, 32'h300, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 5'd8);
    tick(); if32.in_valid = 1'b0; if32.mem_gnt = 1'b1;
    tick(); if32.mem_gnt = 1'b0;
    sample();
    check("rr_in_resp",   64'(busy32), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    sample();
    check("rr_busy",      64'(busy32), 64'd0);
    check("rr_mem_req",   64'(if32.mem_req), 64'd0);
    if32.mem_rvalid = 1'b1; if32.mem_rdata = 32'h12345678;
    tick(); if32.mem_rvalid = 1'b0;
    sample();
    check("rr_late_valid", 64'(if32.wb_valid), 64'd0);
    check("rr_late_busy",  64'(busy32), 64'd0);

    // DATA_W=64: double load at 0x8 is aligned
    offer64(64'h8, 64'h0, 1'b0, 1'b1, 1'b0, 2'b11, 5'd3);
    tick(); if64.in_valid = 1'b0;
    sample();
    check("d64_req",      64'(if64.mem_req), 64'd1);
    check("d64_addr",     64'(if64.mem_addr), 64'h8);
    check("d64_be",       64'(if64.mem_be), 64'hFF);
    if64.mem_gnt = 1'b1;
    tick(); if64.mem_gnt = 1'b0; if64.mem_rvalid = 1'b1; if64.mem_rdata = 64'h1122334455667788;
    tick(); if64.mem_rvalid = 1'b0;
    sample();
    check("d64_wb_data",  if64.wb_data, 64'h1122334455667788);
    check("d64_wb_exc",   64'(if64.wb_exc), 64'd0);
    tick();

    // DATA_W=64: signed word load at 0xC extends bit 31
    offer64(64'hC, 64'h0, 1'b0, 1'b1, 1'b1, 2'b10, 5'd3);
    tick(); if64.in_valid = 1'b0; if64.mem_gnt = 1'b1;
    tick(); if64.mem_gnt = 1'b0; if64.mem_rvalid = 1'b1; if64.mem_rdata = 64'h8765432100000000;
    tick(); if64.mem_rvalid = 1'b0;
    sample();
    check("lw64_wb_data", if64.wb_data, 64'hFFFFFFFF87654321);
    tick();

    // DATA_W=64: word store at 0xC lands on upper lanes
    offer64(64'hC, 64'h00000000DEADBEEF, 1'b1, 1'b0, 1'b0, 2'b10, 5'd0);
    tick(); if64.in_valid = 1'b0;
    sample();
    check("sw64_addr",    64'(if64.mem_addr), 64'h8);
    check("sw64_be",      64'(if64.mem_be), 64'hF0);
    check("sw64_wdata",   if64.mem_wdata, 64'hDEADBEEF00000000);
    if64.mem_gnt = 1'b1;
    tick(); if64.mem_gnt = 1'b0;
    tick();

    // DATA_W=64: double at 0x4 is misaligned
    offer64(64'h4, 64'h0, 1'b0, 1'b1, 1'b0, 2'b11, 5'd3);
    tick(); if64.in_valid = 1'b0;
    sample();
    check("d64_mis_exc",  64'(if64.wb_exc), 64'd1);
    check("d64_mis_req",  64'(if64.mem_req), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
